// File: rtl/dnn_fix_pkg.sv
// Shared types and helpers for the fixed-point fully-connected layer engine.
//   act_mode_t  : activation selected for a run
//   state_t     : engine FSM states (exposed on the top-level debug port)
//   sat_rescale : arithmetic right shift by the fractional bits, then clamp
//                 to the signed range of a DATA_WIDTH word. Works on a 64-bit
//                 container, so accumulators up to 64 bits are supported.
package dnn_fix_pkg;

  typedef enum logic [1:0] {
    ACT_SIGMOID  = 2'd0,
    ACT_IDENTITY = 2'd1,
    ACT_RELU     = 2'd2
  } act_mode_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH_A = 3'd1,
    FETCH_W = 3'd2,
    FETCH_B = 3'd3,
    LUT     = 3'd4,
    WRITE   = 3'd5,
    DONE    = 3'd6
  } state_t;

  function automatic logic signed [63:0] sat_rescale(input logic signed [63:0] acc,
                                                     input int frac_bits,
                                                     input int data_width);
    logic signed [63:0] v;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    v  = acc >>> frac_bits;
    hi = (64'sd1 <<< (data_width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_width - 1));
    if (v > hi) begin
      v = hi;
    end else if (v < lo) begin
      v = lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/dnn_mac_sat.sv
// Signed multiply-accumulate with rescaled, saturated output.
//   clk_i, rst_i : clock, synchronous active-high reset (clears accumulator)
//   clr_i        : clear accumulator to zero (wins over en_i)
//   en_i         : add a_i*b_i (full-width signed product) into accumulator
//   a_i, b_i     : signed DATA_WIDTH operands
//   sat_o        : accumulator >>> FRAC_BITS, clamped to DATA_WIDTH signed
module dnn_mac_sat
  import dnn_fix_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 14,
  parameter int ACC_WIDTH  = 41
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] sat_o
);

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]    acc_q;
  logic signed [ACC_WIDTH-1:0]    acc_d;

  // Operands are sign-extended explicitly so the product is exact at 2*DATA_WIDTH.
  assign prod = $signed({{DATA_WIDTH{a_i[DATA_WIDTH-1]}}, a_i})
              * $signed({{DATA_WIDTH{b_i[DATA_WIDTH-1]}}, b_i});

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + ACC_WIDTH'(prod);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign sat_o = DATA_WIDTH'(sat_rescale(64'(acc_q), FRAC_BITS, DATA_WIDTH));

endmodule

// File: rtl/dnn_fc_layer_fix.sv
// Fixed-point fully-connected layer: for each neuron j computes
// act(sum_i A[i]*W[j][i] + W[j][N_IN]*1.0) over one shared read-only port.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   start_i        : begin a run (accepted in IDLE or DONE)
//   reset_i        : synchronous soft clear, same effect as rst_i
//   act_mode_i     : 0 sigmoid LUT, 1/3 identity, 2 ReLU (sampled with start)
//   mem_data_i     : read data, valid MEM_LATENCY cycles after the address
//   mem_addr_o     : read address, held for MEM_LATENCY+1 cycles per read
//   busy_o, done_o : run in progress / results valid
//   out_o          : neuron outputs, out[j] = out_o[j*DATA_WIDTH +: DATA_WIDTH]
//   class_idx_o    : index of the largest output (lowest index on ties)
//   state_o        : current FSM state (debug)
// Handshake: start_i is a single-cycle request, honoured only when busy_o=0;
// done_o stays high until the next accepted start or a clear.
module dnn_fc_layer_fix
  import dnn_fix_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int FRAC_BITS     = 14,
  parameter int ADDR_WIDTH    = 18,
  parameter int N_IN          = 400,
  parameter int N_OUT         = 10,
  parameter int ADDR_BASE_A   = 0,
  parameter int ADDR_BASE_W   = 'h191,
  parameter int ADDR_BASE_LUT = 'h29be,
  parameter int LUT_ADDR_BITS = 8,
  parameter int MEM_LATENCY   = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic                        reset_i,
  input  logic [1:0]                  act_mode_i,
  input  logic [DATA_WIDTH-1:0]       mem_data_i,
  output logic [ADDR_WIDTH-1:0]       mem_addr_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [N_OUT*DATA_WIDTH-1:0] out_o,
  output logic [$clog2(N_OUT)-1:0]    class_idx_o,
  output logic [2:0]                  state_o
);

  localparam int ACC_WIDTH = 2 * DATA_WIDTH + $clog2(N_IN + 1);
  localparam int IW        = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int JW        = $clog2(N_OUT);
  localparam int WW        = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY + 1) : 1;
  localparam int ROW       = N_IN + 1;
  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1 << FRAC_BITS);

  state_t                      state_q, state_d;
  act_mode_t                   mode_q, mode_d;
  logic [IW-1:0]               i_q, i_d;
  logic [JW-1:0]               j_q, j_d;
  logic [WW-1:0]               wait_q, wait_d;
  logic [ADDR_WIDTH-1:0]       addr_q, fetch_addr;
  logic [DATA_WIDTH-1:0]       a_q, a_d;
  logic [DATA_WIDTH-1:0]       lut_q, lut_d;
  logic [DATA_WIDTH-1:0]       max_q, max_d;
  logic [N_OUT*DATA_WIDTH-1:0] out_q, out_d;
  logic [JW-1:0]               class_q, class_d;

  logic                        clear;
  logic                        last_rd;
  logic                        mac_clr, mac_en;
  logic [DATA_WIDTH-1:0]       mac_a, mac_b;
  logic [DATA_WIDTH-1:0]       sat_v;
  logic [DATA_WIDTH-1:0]       y;
  logic [LUT_ADDR_BITS-1:0]    lut_idx;
  logic [ADDR_WIDTH-1:0]       w_row;

  assign clear   = rst_i | reset_i;
  assign last_rd = (wait_q == WW'(MEM_LATENCY));

  dnn_mac_sat #(
    .DATA_WIDTH(DATA_WIDTH),
    .FRAC_BITS (FRAC_BITS),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .clk_i(clk_i),
    .rst_i(clear),
    .clr_i(mac_clr),
    .en_i (mac_en),
    .a_i  (mac_a),
    .b_i  (mac_b),
    .sat_o(sat_v)
  );

  // Offset-binary LUT index: top bits of the rescaled sum with the sign flipped,
  // so the most negative value maps to entry 0.
  assign lut_idx = {~sat_v[DATA_WIDTH-1], sat_v[DATA_WIDTH-2 -: LUT_ADDR_BITS-1]};
  assign w_row   = ADDR_WIDTH'(ADDR_BASE_W + int'(j_q) * ROW);

  // The address is a function of the current read state, so it is valid on the
  // issue cycle; outside reads the last address is held in addr_q.
  always_comb begin
    fetch_addr = addr_q;
    case (state_q)
      FETCH_A: fetch_addr = ADDR_WIDTH'(ADDR_BASE_A + int'(i_q));
      FETCH_W: fetch_addr = w_row + ADDR_WIDTH'(i_q);
      FETCH_B: fetch_addr = w_row + ADDR_WIDTH'(N_IN);
      LUT:     fetch_addr = ADDR_WIDTH'(ADDR_BASE_LUT) + ADDR_WIDTH'(lut_idx);
      default: fetch_addr = addr_q;
    endcase
  end

  always_comb begin
    case (mode_q)
      ACT_SIGMOID: y = lut_q;
      ACT_RELU:    y = sat_v[DATA_WIDTH-1] ? {DATA_WIDTH{1'b0}} : sat_v;
      default:     y = sat_v;
    endcase
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    i_d     = i_q;
    j_d     = j_q;
    wait_d  = wait_q;
    a_d     = a_q;
    lut_d   = lut_q;
    max_d   = max_q;
    out_d   = out_q;
    class_d = class_q;
    mac_clr = 1'b0;
    mac_en  = 1'b0;
    mac_a   = a_q;
    mac_b   = mem_data_i;

    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          case (act_mode_i)
            2'd0:    mode_d = ACT_SIGMOID;
            2'd2:    mode_d = ACT_RELU;
            default: mode_d = ACT_IDENTITY;
          endcase
          out_d   = '0;
          class_d = '0;
          max_d   = '0;
          i_d     = '0;
          j_d     = '0;
          wait_d  = '0;
          mac_clr = 1'b1;
          state_d = FETCH_A;
        end
      end
      FETCH_A: begin
        wait_d = wait_q + WW'(1);
        if (last_rd) begin
          a_d     = mem_data_i;
          wait_d  = '0;
          state_d = FETCH_W;
        end
      end
      FETCH_W: begin
        wait_d = wait_q + WW'(1);
        if (last_rd) begin
          mac_en = 1'b1;
          wait_d = '0;
          if (i_q == IW'(N_IN - 1)) begin
            state_d = FETCH_B;
          end else begin
            i_d     = i_q + IW'(1);
            state_d = FETCH_A;
          end
        end
      end
      FETCH_B: begin
        wait_d = wait_q + WW'(1);
        if (last_rd) begin
          // Bias rides on an implicit input of 1.0.
          mac_en  = 1'b1;
          mac_a   = mem_data_i;
          mac_b   = ONE;
          wait_d  = '0;
          state_d = (mode_q == ACT_SIGMOID) ? LUT : WRITE;
        end
      end
      LUT: begin
        wait_d = wait_q + WW'(1);
        if (last_rd) begin
          lut_d   = mem_data_i;
          wait_d  = '0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        out_d[int'(j_q)*DATA_WIDTH +: DATA_WIDTH] = y;
        if ((j_q == '0) || ($signed(y) > $signed(max_q))) begin
          max_d   = y;
          class_d = j_q;
        end
        if (j_q == JW'(N_OUT - 1)) begin
          state_d = DONE;
        end else begin
          j_d     = j_q + JW'(1);
          i_d     = '0;
          mac_clr = 1'b1;
          state_d = FETCH_A;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (clear) begin
      state_q <= IDLE;
      mode_q  <= ACT_SIGMOID;
      i_q     <= '0;
      j_q     <= '0;
      wait_q  <= '0;
      addr_q  <= '0;
      a_q     <= '0;
      lut_q   <= '0;
      max_q   <= '0;
      out_q   <= '0;
      class_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      i_q     <= i_d;
      j_q     <= j_d;
      wait_q  <= wait_d;
      addr_q  <= fetch_addr;
      a_q     <= a_d;
      lut_q   <= lut_d;
      max_q   <= max_d;
      out_q   <= out_d;
      class_q <= class_d;
    end
  end

  assign mem_addr_o  = fetch_addr;
  assign busy_o      = (state_q != IDLE) && (state_q != DONE);
  assign done_o      = (state_q == DONE);
  assign out_o       = out_q;
  assign class_idx_o = class_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_dnn_fc_layer_fix.sv
// Bench for dnn_fc_layer_fix: two instances (read latency 1 and 3) share one
// behavioural memory; results are compared with a plain-arithmetic model.
module tb_dnn_fc_layer_fix;
  import dnn_fix_pkg::*;

  localparam int DW = 16;
  localparam int AW = 18;
  localparam int NI = 2;
  localparam int NO = 3;
  localparam int CW = 2;
  localparam int BW = 'h191;
  localparam int BL = 'h29be;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic             start_s [2];
  logic             reset_s [2];
  logic [1:0]       mode_s  [2];
  logic [DW-1:0]    mdata_s [2];
  logic [AW-1:0]    maddr_s [2];
  logic             busy_s  [2];
  logic             done_s  [2];
  logic [NO*DW-1:0] out_s   [2];
  logic [CW-1:0]    cls_s   [2];
  logic [2:0]       st_s    [2];

  logic [DW-1:0] mem [0:(1<<AW)-1];

  dnn_fc_layer_fix #(.N_IN(NI), .N_OUT(NO), .MEM_LATENCY(1)) u_dut_l1 (
    .clk_i(clk), .rst_i(rst), .start_i(start_s[0]), .reset_i(reset_s[0]),
    .act_mode_i(mode_s[0]), .mem_data_i(mdata_s[0]), .mem_addr_o(maddr_s[0]),
    .busy_o(busy_s[0]), .done_o(done_s[0]), .out_o(out_s[0]),
    .class_idx_o(cls_s[0]), .state_o(st_s[0]));

  dnn_fc_layer_fix #(.N_IN(NI), .N_OUT(NO), .MEM_LATENCY(3)) u_dut_l3 (
    .clk_i(clk), .rst_i(rst), .start_i(start_s[1]), .reset_i(reset_s[1]),
    .act_mode_i(mode_s[1]), .mem_data_i(mdata_s[1]), .mem_addr_o(maddr_s[1]),
    .busy_o(busy_s[1]), .done_o(done_s[1]), .out_o(out_s[1]),
    .class_idx_o(cls_s[1]), .state_o(st_s[1]));

  // Memory: data for an address appears LAT cycles after it is presented.
  logic [AW-1:0] p1;
  logic [AW-1:0] p3 [3];
  always @(posedge clk) begin
    p1    <= maddr_s[0];
    p3[0] <= maddr_s[1];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign mdata_s[0] = mem[p1];
  assign mdata_s[1] = mem[p3[2]];

  // ---------------- monitors ----------------
  logic          mon_clr;
  int            lut_hits;
  logic [AW-1:0] prev0;
  always @(negedge clk) begin
    if (mon_clr) begin
      lut_hits <= 0;
    end else if (maddr_s[0] == AW'(BL + 'h80) && prev0 != maddr_s[0]) begin
      lut_hits <= lut_hits + 1;
    end
    prev0 <= maddr_s[0];
  end

  // Length of each run of a constant address during reads on the latency-3 DUT.
  logic          fetch1;
  logic          h_prev_fetch;
  logic [AW-1:0] h_prev_addr;
  int            h_len, h_segs, h_bad;
  assign fetch1 = (st_s[1] == FETCH_A) || (st_s[1] == FETCH_W) ||
                  (st_s[1] == FETCH_B) || (st_s[1] == LUT);
  always @(negedge clk) begin
    if (mon_clr) begin
      h_len <= 0; h_segs <= 0; h_bad <= 0; h_prev_fetch <= 1'b0;
    end else begin
      if (fetch1 && h_prev_fetch && maddr_s[1] == h_prev_addr) begin
        h_len <= h_len + 1;
      end else begin
        if (h_prev_fetch) begin
          h_segs <= h_segs + 1;
          if (h_len != 4) h_bad <= h_bad + 1;
        end
        h_len <= fetch1 ? 1 : 0;
      end
      h_prev_fetch <= fetch1;
    end
    h_prev_addr <= maddr_s[1];
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_out [NO];
  int            exp_cls;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer dot product, floor shift, clamp, activation, argmax.
  task automatic model(input int mode);
    longint acc, v, y, best;
    best = 0;
    exp_cls = 0;
    for (int j = 0; j < NO; j++) begin
      acc = 0;
      for (int i = 0; i < NI; i++)
        acc += longint'($signed(mem[i])) * longint'($signed(mem[BW + j*(NI+1) + i]));
      acc += longint'($signed(mem[BW + j*(NI+1) + NI])) * 16384;
      v = acc >>> 14;
      if (v > 32767) v = 32767;
      if (v < -32768) v = -32768;
      case (mode)
        0:       y = longint'($signed(mem[BL + int'((v + 32768) >>> 8)]));
        2:       y = (v < 0) ? 0 : v;
        default: y = v;
      endcase
      if (j == 0 || y > best) begin
        best = y;
        exp_cls = j;
      end
      exp_out[j] = DW'(y);
    end
  endtask

  function automatic int exp_lat(input int mode, input int lat);
    int r;
    r = 2*NI + 1 + ((mode == 0) ? 1 : 0);
    return NO * (r * (lat + 1) + 1) + 1;
  endfunction

  // ---------------- drivers ----------------
  task automatic set_w(input int j, input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                       input logic [DW-1:0] b);
    mem[BW + j*(NI+1)]     = w0;
    mem[BW + j*(NI+1) + 1] = w1;
    mem[BW + j*(NI+1) + 2] = b;
  endtask

  task automatic load_case1();
    mem[0] = 16'h2000; mem[1] = 16'h1000;
    set_w(0, 16'h4000, 16'h4000, 16'h0000);
    set_w(1, 16'h0000, 16'h0000, 16'h1000);
    set_w(2, 16'h4000, 16'h0000, 16'h0000);
  endtask

  task automatic clear_mon();
    @(negedge clk); mon_clr = 1'b1;
    @(negedge clk); mon_clr = 1'b0;
  endtask

  // Start a run and wait for done; optionally pulse start (with a different
  // mode) mid-run, which must be ignored.
  task automatic run(input int k, input int mode, input bit poke, output int lat);
    @(negedge clk); start_s[k] = 1'b1; mode_s[k] = 2'(mode);
    @(negedge clk); start_s[k] = 1'b0; lat = 1;
    check_eq($sformatf("done_clr%0d", k), 64'(done_s[k]), 64'd0);
    check_eq($sformatf("busy_set%0d", k), 64'(busy_s[k]), 64'd1);
    while (!done_s[k] && lat < 2000) begin
      if (poke && lat == 6) begin
        start_s[k] = 1'b1; mode_s[k] = ~2'(mode);
      end else begin
        start_s[k] = 1'b0; mode_s[k] = 2'(mode);
      end
      @(negedge clk); lat++;
    end
    start_s[k] = 1'b0;
    if (!done_s[k]) check_eq($sformatf("timeout%0d", k), 64'd0, 64'd1);
  endtask

  task automatic check_run(input string tag, input int k, input int mode, input int lat,
                           input int lat_got);
    model(mode);
    for (int j = 0; j < NO; j++)
      check_eq($sformatf("%s_out%0d", tag, j), 64'(out_s[k][j*DW +: DW]), 64'(exp_out[j]));
    check_eq({tag, "_cls"},  64'(cls_s[k]),  64'(exp_cls));
    check_eq({tag, "_done"}, 64'(done_s[k]), 64'd1);
    check_eq({tag, "_busy"}, 64'(busy_s[k]), 64'd0);
    check_eq({tag, "_lat"},  64'(lat_got),   64'(exp_lat(mode, lat)));
  endtask

  task automatic check_cleared(input string tag, input int k);
    check_eq({tag, "_st"},   64'(st_s[k]),    64'(IDLE));
    check_eq({tag, "_out"},  64'(out_s[k]),   64'd0);
    check_eq({tag, "_cls"},  64'(cls_s[k]),   64'd0);
    check_eq({tag, "_busy"}, 64'(busy_s[k]),  64'd0);
    check_eq({tag, "_done"}, 64'(done_s[k]),  64'd0);
    check_eq({tag, "_addr"}, 64'(maddr_s[k]), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int lat, mode, k, guard;
    rst = 1'b1; mon_clr = 1'b1;
    for (int q = 0; q < 2; q++) begin
      start_s[q] = 1'b0; reset_s[q] = 1'b0; mode_s[q] = 2'd0;
    end
    for (int a = 0; a < (1 << AW); a++) mem[a] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0; mon_clr = 1'b0;
    @(negedge clk);
    check_cleared("rst_l1", 0);
    check_cleared("rst_l3", 1);

    // Case 1 (latency 1) and case 4 (same stimulus, latency 3).
    load_case1();
    run(0, 1, 1'b0, lat);
    check_run("c1", 0, 1, 1, lat);
    check_eq("c1_out0_const", 64'(out_s[0][DW-1:0]), 64'h3000);
    clear_mon();
    run(1, 1, 1'b0, lat);
    check_run("c4", 1, 1, 3, lat);
    repeat (2) @(negedge clk);
    check_eq("c4_segs", 64'(h_segs), 64'd15);
    check_eq("c4_hold", 64'(h_bad),  64'd0);

    // Case 2: saturation and ReLU.
    set_w(0, 16'h7fff, 16'h7fff, 16'h7fff);
    set_w(1, 16'hc000, 16'h0000, 16'h0000);
    set_w(2, 16'h0000, 16'h0000, 16'h0000);
    run(0, 2, 1'b0, lat);
    check_run("c2", 0, 2, 1, lat);
    check_eq("c2_sat",  64'(out_s[0][DW-1:0]),  64'h7fff);
    check_eq("c2_relu", 64'(out_s[0][2*DW-1:DW]), 64'h0000);

    // Case 3: sigmoid with zero sums -> LUT[0x80] for every neuron.
    for (int j = 0; j < NO; j++) set_w(j, '0, '0, '0);
    mem[BL + 'h80] = 16'h2000;
    clear_mon();
    run(0, 0, 1'b0, lat);
    check_run("c3", 0, 0, 1, lat);
    check_eq("c3_out2",  64'(out_s[0][3*DW-1:2*DW]), 64'h2000);
    check_eq("c3_hits",  64'(lut_hits), 64'd3);

    // Case 5: soft clear with start during neuron 1's weight fetch.
    load_case1();
    @(negedge clk); start_s[0] = 1'b1; mode_s[0] = 2'd1;
    @(negedge clk); start_s[0] = 1'b0;
    guard = 0;
    while (st_s[0] != WRITE && guard < 500) begin @(negedge clk); guard++; end
    while (st_s[0] != FETCH_W && guard < 500) begin @(negedge clk); guard++; end
    check_eq("c5_reach", 64'(guard < 500), 64'd1);
    check_eq("c5_partial", 64'(out_s[0][DW-1:0]), 64'h3000);
    reset_s[0] = 1'b1; start_s[0] = 1'b1;
    @(negedge clk); reset_s[0] = 1'b0; start_s[0] = 1'b0;
    check_cleared("c5_clr", 0);
    run(0, 1, 1'b0, lat);
    check_run("c5_rerun", 0, 1, 1, lat);

    // Case 6: start while busy is ignored; start in DONE restarts.
    run(0, 1, 1'b1, lat);
    check_run("c6_poke", 0, 1, 1, lat);
    run(0, 1, 1'b0, lat);
    check_run("c6_redo", 0, 1, 1, lat);

    // Randomised runs on both latencies, all activation modes.
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < NI; i++)
        mem[i] = (it % 2 == 0) ? DW'($urandom_range(0, 65535))
                               : DW'(int'($urandom_range(0, 8191)) - 4096);
      for (int a = 0; a < NO*(NI+1); a++)
        mem[BW + a] = (it % 2 == 0) ? DW'($urandom_range(0, 65535))
                                    : DW'(int'($urandom_range(0, 16383)) - 8192);
      for (int e = 0; e < 256; e++) mem[BL + e] = DW'($urandom_range(0, 65535));
      mode = int'($urandom_range(0, 3));
      k = it % 2;
      run(k, mode, 1'b0, lat);
      check_run($sformatf("rnd%0d", it), k, mode, (k == 0) ? 1 : 3, lat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
